// File: rtl/reorder_buffer.sv
// In-order retirement queue: allocates at tail, captures ALU/LSB results, retires one entry per cycle at head.
// Retire outputs are registered one edge after the head becomes ready; a full ROB or a rollback cycle rejects issue.
module reorder_buffer #(
  parameter int ROB_SIZE = 16,
  parameter int POS_WID  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  output logic               rob_full,
  input  logic               issue,
  input  logic [1:0]         issue_type,
  input  logic [4:0]         issue_rd,
  input  logic [31:0]        issue_pc,
  input  logic               issue_pred_jump,
  input  logic               issue_ready,
  input  logic [31:0]        issue_val,
  output logic [POS_WID-1:0] issue_rob_pos,
  input  logic               alu_result,
  input  logic [POS_WID-1:0] alu_rob_pos,
  input  logic [31:0]        alu_val,
  input  logic               alu_jump,
  input  logic [31:0]        alu_target_pc,
  input  logic               lsb_result,
  input  logic [POS_WID-1:0] lsb_rob_pos,
  input  logic [31:0]        lsb_val,
  input  logic [POS_WID-1:0] rs1_q_pos,
  output logic               rs1_q_ready,
  output logic [31:0]        rs1_q_val,
  input  logic [POS_WID-1:0] rs2_q_pos,
  output logic               rs2_q_ready,
  output logic [31:0]        rs2_q_val,
  output logic               commit,
  output logic [4:0]         commit_rd,
  output logic [31:0]        commit_val,
  output logic [POS_WID-1:0] commit_rob_pos,
  output logic               commit_store,
  output logic               commit_br,
  output logic [31:0]        commit_br_pc,
  output logic               commit_br_jump,
  output logic               rollback,
  output logic [31:0]        rollback_pc
);
  localparam logic [1:0] T_BR = 2'd1;
  localparam logic [1:0] T_ST = 2'd2;

  logic [ROB_SIZE-1:0] r_busy;
  logic [ROB_SIZE-1:0] r_ready;
  logic [1:0]          r_type   [ROB_SIZE];
  logic [4:0]          r_rd     [ROB_SIZE];
  logic [31:0]         r_val    [ROB_SIZE];
  logic [31:0]         r_pc     [ROB_SIZE];
  logic                r_pred   [ROB_SIZE];
  logic                r_jump   [ROB_SIZE];
  logic [31:0]         r_tgt    [ROB_SIZE];
  logic [POS_WID-1:0]  r_head;
  logic [POS_WID-1:0]  r_tail;
  logic [POS_WID:0]    r_count;

  logic w_issue_ok;
  logic w_retire;
  logic w_mispredict;

  assign rob_full      = (r_count == (POS_WID+1)'(ROB_SIZE));
  assign issue_rob_pos = r_tail;
  assign w_issue_ok    = rdy && issue && !rob_full && !rollback;
  assign w_retire      = rdy && (r_count != '0) && r_ready[r_head];
  assign w_mispredict  = w_retire && (r_type[r_head] == T_BR) && (r_jump[r_head] != r_pred[r_head]);

  // Same-cycle broadcasts are bypassed to the decoder; ALU wins over LSB.
  always_comb begin
    rs1_q_ready = r_ready[rs1_q_pos];
    rs1_q_val   = r_val[rs1_q_pos];
    rs2_q_ready = r_ready[rs2_q_pos];
    rs2_q_val   = r_val[rs2_q_pos];
    if (lsb_result && lsb_rob_pos == rs1_q_pos) begin
      rs1_q_ready = 1'b1;
      rs1_q_val   = lsb_val;
    end
    if (alu_result && alu_rob_pos == rs1_q_pos) begin
      rs1_q_ready = 1'b1;
      rs1_q_val   = alu_val;
    end
    if (lsb_result && lsb_rob_pos == rs2_q_pos) begin
      rs2_q_ready = 1'b1;
      rs2_q_val   = lsb_val;
    end
    if (alu_result && alu_rob_pos == rs2_q_pos) begin
      rs2_q_ready = 1'b1;
      rs2_q_val   = alu_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy         <= '0;
      r_ready        <= '0;
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
      commit         <= 1'b0;
      commit_rd      <= '0;
      commit_val     <= '0;
      commit_rob_pos <= '0;
      commit_store   <= 1'b0;
      commit_br      <= 1'b0;
      commit_br_pc   <= '0;
      commit_br_jump <= 1'b0;
      rollback       <= 1'b0;
      rollback_pc    <= '0;
    end else if (rdy) begin
      commit       <= 1'b0;
      commit_store <= 1'b0;
      commit_br    <= 1'b0;
      rollback     <= 1'b0;
      if (w_retire) begin
        commit_rob_pos <= r_head;
        case (r_type[r_head])
          T_BR: begin
            commit_br      <= 1'b1;
            commit_br_pc   <= r_pc[r_head];
            commit_br_jump <= r_jump[r_head];
          end
          T_ST:    commit_store <= 1'b1;
          default: begin
            commit     <= 1'b1;
            commit_rd  <= r_rd[r_head];
            commit_val <= r_val[r_head];
          end
        endcase
      end
      if (w_mispredict) begin
        rollback    <= 1'b1;
        rollback_pc <= r_jump[r_head] ? r_tgt[r_head] : r_pc[r_head] + 32'd4;
        r_busy      <= '0;
        r_ready     <= '0;
        r_head      <= '0;
        r_tail      <= '0;
        r_count     <= '0;
      end else begin
        if (!rollback) begin
          if (lsb_result && r_busy[lsb_rob_pos]) begin
            r_ready[lsb_rob_pos] <= 1'b1;
            r_val[lsb_rob_pos]   <= lsb_val;
          end
          if (alu_result && r_busy[alu_rob_pos]) begin
            r_ready[alu_rob_pos] <= 1'b1;
            r_val[alu_rob_pos]   <= alu_val;
            r_jump[alu_rob_pos]  <= alu_jump;
            r_tgt[alu_rob_pos]   <= alu_target_pc;
          end
        end
        // A branch assumes its prediction until the ALU reports the real outcome.
        if (w_issue_ok) begin
          r_busy[r_tail]  <= 1'b1;
          r_ready[r_tail] <= issue_ready;
          r_type[r_tail]  <= issue_type;
          r_rd[r_tail]    <= issue_rd;
          r_val[r_tail]   <= issue_val;
          r_pc[r_tail]    <= issue_pc;
          r_pred[r_tail]  <= issue_pred_jump;
          r_jump[r_tail]  <= issue_pred_jump;
          r_tgt[r_tail]   <= '0;
          r_tail          <= r_tail + 1'b1;
        end
        if (w_retire) begin
          r_busy[r_head]  <= 1'b0;
          r_ready[r_head] <= 1'b0;
          r_head          <= r_head + 1'b1;
        end
        r_count <= r_count + (POS_WID+1)'(w_issue_ok) - (POS_WID+1)'(w_retire);
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed vector table, corner-case sequences, then random traffic vs a queue model.
module tb_reorder_buffer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rdy, issue, issue_pred_jump, issue_ready;
  logic [1:0] issue_type;
  logic [4:0] issue_rd;
  logic [31:0] issue_pc, issue_val;
  logic alu_result, alu_jump, lsb_result;
  logic [3:0] alu_rob_pos, lsb_rob_pos, rs1_q_pos, rs2_q_pos;
  logic [31:0] alu_val, alu_target_pc, lsb_val;
  logic rob_full, rs1_q_ready, rs2_q_ready, commit, commit_store, commit_br, commit_br_jump, rollback;
  logic [3:0] issue_rob_pos, commit_rob_pos;
  logic [4:0] commit_rd;
  logic [31:0] rs1_q_val, rs2_q_val, commit_val, commit_br_pc, rollback_pc;

  reorder_buffer #(.ROB_SIZE(16), .POS_WID(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rob_full(rob_full),
    .issue(issue), .issue_type(issue_type), .issue_rd(issue_rd), .issue_pc(issue_pc),
    .issue_pred_jump(issue_pred_jump), .issue_ready(issue_ready), .issue_val(issue_val),
    .issue_rob_pos(issue_rob_pos),
    .alu_result(alu_result), .alu_rob_pos(alu_rob_pos), .alu_val(alu_val), .alu_jump(alu_jump),
    .alu_target_pc(alu_target_pc),
    .lsb_result(lsb_result), .lsb_rob_pos(lsb_rob_pos), .lsb_val(lsb_val),
    .rs1_q_pos(rs1_q_pos), .rs1_q_ready(rs1_q_ready), .rs1_q_val(rs1_q_val),
    .rs2_q_pos(rs2_q_pos), .rs2_q_ready(rs2_q_ready), .rs2_q_val(rs2_q_val),
    .commit(commit), .commit_rd(commit_rd), .commit_val(commit_val), .commit_rob_pos(commit_rob_pos),
    .commit_store(commit_store), .commit_br(commit_br), .commit_br_pc(commit_br_pc),
    .commit_br_jump(commit_br_jump), .rollback(rollback), .rollback_pc(rollback_pc)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: program-ordered list of in-flight instructions, each tagged with its slot.
  typedef struct {
    int pos; bit [1:0] ty; bit [4:0] rd; bit [31:0] pc; bit pred;
    bit ok; bit [31:0] val; bit jump; bit [31:0] tgt;
  } ent_t;
  ent_t q[$];
  int m_tail = 0;
  bit m_commit, m_store, m_br, m_brj, m_rb;
  bit [4:0] m_rd;
  bit [31:0] m_val, m_brpc, m_rbpc;
  int m_cpos;

  function automatic void mq(input logic [3:0] p, output bit r, output logic [31:0] v);
    r = 0; v = 0;
    foreach (q[i]) if (q[i].pos == int'(p) && q[i].ok) begin r = 1; v = q[i].val; end
    if (lsb_result && lsb_rob_pos == p) begin r = 1; v = lsb_val; end
    if (alu_result && alu_rob_pos == p) begin r = 1; v = alu_val; end
  endfunction

  task automatic model_step();
    bit ret, rb_pre, full_pre;
    ent_t e, n;
    if (rst) begin
      q.delete(); m_tail = 0;
      {m_commit, m_store, m_br, m_brj, m_rb} = '0;
      m_rd = 0; m_val = 0; m_brpc = 0; m_rbpc = 0; m_cpos = 0;
      return;
    end
    if (!rdy) return;
    ret = q.size() > 0 && q[0].ok;
    if (ret) e = q[0];
    rb_pre = m_rb;
    full_pre = q.size() == 16;
    {m_commit, m_store, m_br, m_rb} = '0;
    if (ret) begin
      m_cpos = e.pos;
      if (e.ty == 1) begin m_br = 1; m_brpc = e.pc; m_brj = e.jump; end
      else if (e.ty == 2) m_store = 1;
      else begin m_commit = 1; m_rd = e.rd; m_val = e.val; end
      if (e.ty == 1 && e.jump != e.pred) begin
        m_rb = 1; m_rbpc = e.jump ? e.tgt : e.pc + 32'd4;
        q.delete(); m_tail = 0;
        return;
      end
    end
    if (!rb_pre) begin
      foreach (q[i]) if (lsb_result && q[i].pos == int'(lsb_rob_pos)) begin q[i].ok = 1; q[i].val = lsb_val; end
      foreach (q[i]) if (alu_result && q[i].pos == int'(alu_rob_pos)) begin
        q[i].ok = 1; q[i].val = alu_val; q[i].jump = alu_jump; q[i].tgt = alu_target_pc;
      end
    end
    if (issue && !full_pre && !rb_pre) begin
      n = '{m_tail, issue_type, issue_rd, issue_pc, issue_pred_jump, issue_ready, issue_val, issue_pred_jump, 32'd0};
      q.push_back(n);
      m_tail = (m_tail + 1) % 16;
    end
    if (ret) void'(q.pop_front());
  endtask

  task automatic check_comb();
    bit r; logic [31:0] v;
    chk("rob_full", 32'(rob_full), 32'(q.size() == 16));
    chk("issue_rob_pos", 32'(issue_rob_pos), m_tail);
    mq(rs1_q_pos, r, v);
    chk("rs1_q_ready", 32'(rs1_q_ready), 32'(r));
    if (r) chk("rs1_q_val", rs1_q_val, v);
    mq(rs2_q_pos, r, v);
    chk("rs2_q_ready", 32'(rs2_q_ready), 32'(r));
    if (r) chk("rs2_q_val", rs2_q_val, v);
  endtask

  task automatic check_regs();
    chk("commit", 32'(commit), 32'(m_commit));
    chk("commit_rd", 32'(commit_rd), 32'(m_rd));
    chk("commit_val", commit_val, m_val);
    chk("commit_rob_pos", 32'(commit_rob_pos), m_cpos);
    chk("commit_store", 32'(commit_store), 32'(m_store));
    chk("commit_br", 32'(commit_br), 32'(m_br));
    chk("commit_br_pc", commit_br_pc, m_brpc);
    chk("commit_br_jump", 32'(commit_br_jump), 32'(m_brj));
    chk("rollback", 32'(rollback), 32'(m_rb));
    chk("rollback_pc", rollback_pc, m_rbpc);
  endtask

  // Inputs are driven at negedge; combinational outputs checked 1 ns later, registered ones at the next negedge.
  task automatic cycle();
    #1 check_comb();
    model_step();
    @(negedge clk);
    check_regs();
  endtask

  task automatic idle();
    rst = 0; rdy = 1; issue = 0; issue_type = 0; issue_rd = 0; issue_pc = 0;
    issue_pred_jump = 0; issue_ready = 0; issue_val = 0;
    alu_result = 0; alu_rob_pos = 0; alu_val = 0; alu_jump = 0; alu_target_pc = 0;
    lsb_result = 0; lsb_rob_pos = 0; lsb_val = 0; rs1_q_pos = 0; rs2_q_pos = 0;
  endtask

  task automatic set_iss(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pc,
                         input bit pred, input bit rdy_now, input logic [31:0] v);
    issue = 1; issue_type = t; issue_rd = rd; issue_pc = pc;
    issue_pred_jump = pred; issue_ready = rdy_now; issue_val = v;
  endtask

  task automatic set_alu(input logic [3:0] p, input logic [31:0] v, input bit j, input logic [31:0] t);
    alu_result = 1; alu_rob_pos = p; alu_val = v; alu_jump = j; alu_target_pc = t;
  endtask

  task automatic do_reset();
    idle(); rst = 1; cycle(); idle();
  endtask

  typedef struct {
    bit iss; logic [4:0] rd; bit alu; logic [3:0] apos; logic [31:0] aval;
    logic [3:0] xpos; bit xc; logic [4:0] xrd; logic [31:0] xval; logic [3:0] xcpos;
  } vec_t;
  vec_t tbl[9];

  initial begin
    int idx, idx2;
    idle();
    tbl[0] = '{1, 5'd1, 0, 4'd0, 32'h0,  4'd0, 0, 5'd0, 32'h0,  4'd0};
    tbl[1] = '{1, 5'd2, 0, 4'd0, 32'h0,  4'd1, 0, 5'd0, 32'h0,  4'd0};
    tbl[2] = '{1, 5'd3, 0, 4'd0, 32'h0,  4'd2, 0, 5'd0, 32'h0,  4'd0};
    tbl[3] = '{0, 5'd0, 1, 4'd2, 32'h22, 4'd0, 0, 5'd0, 32'h0,  4'd0};
    tbl[4] = '{0, 5'd0, 1, 4'd0, 32'h11, 4'd0, 0, 5'd0, 32'h0,  4'd0};
    tbl[5] = '{0, 5'd0, 1, 4'd1, 32'h33, 4'd0, 1, 5'd1, 32'h11, 4'd0};
    tbl[6] = '{0, 5'd0, 0, 4'd0, 32'h0,  4'd0, 1, 5'd2, 32'h33, 4'd1};
    tbl[7] = '{0, 5'd0, 0, 4'd0, 32'h0,  4'd0, 1, 5'd3, 32'h22, 4'd2};
    tbl[8] = '{0, 5'd0, 0, 4'd0, 32'h0,  4'd0, 0, 5'd0, 32'h0,  4'd0};
    @(negedge clk);
    do_reset();
    chk("reset_commit", 32'(commit), 0);
    chk("reset_rollback", 32'(rollback), 0);
    chk("reset_full", 32'(rob_full), 0);
    chk("reset_pos", 32'(issue_rob_pos), 0);

    // Out-of-order writeback, in-order commit.
    foreach (tbl[i]) begin
      idle();
      if (tbl[i].iss) set_iss(2'd0, tbl[i].rd, 32'h1000 + 32'(i) * 4, 0, 0, 0);
      if (tbl[i].alu) set_alu(tbl[i].apos, tbl[i].aval, 0, 0);
      #1 if (tbl[i].iss) chk("tbl_issue_pos", 32'(issue_rob_pos), 32'(tbl[i].xpos));
      cycle();
      chk("tbl_commit", 32'(commit), 32'(tbl[i].xc));
      if (tbl[i].xc) begin
        chk("tbl_commit_rd", 32'(commit_rd), 32'(tbl[i].xrd));
        chk("tbl_commit_val", commit_val, tbl[i].xval);
        chk("tbl_commit_pos", 32'(commit_rob_pos), 32'(tbl[i].xcpos));
      end
    end

    // Fill, reject when full, then wrap the tail while retiring.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      idle(); set_iss(2'd0, 5'(i), 32'(i) * 4, 0, 0, 32'(i));
      #1 chk("fill_pos", 32'(issue_rob_pos), i);
      cycle();
    end
    chk("full_flag", 32'(rob_full), 1);
    idle(); set_iss(2'd0, 5'd20, 0, 0, 1, 0); cycle();
    chk("full_reject_tail", 32'(issue_rob_pos), 0);
    idle(); set_alu(4'd0, 32'hA0, 0, 0); cycle();
    idle(); set_alu(4'd1, 32'hA1, 0, 0); set_iss(2'd0, 5'd21, 0, 0, 0, 0); cycle();
    chk("full_retire_commit", 32'(commit), 1);
    chk("full_retire_tail", 32'(issue_rob_pos), 0);
    idle(); set_iss(2'd0, 5'd22, 0, 0, 0, 0); cycle();
    chk("wrap_tail", 32'(issue_rob_pos), 1);
    chk("wrap_commit_val", commit_val, 32'hA1);

    // Mispredict (not taken predicted, taken actual) flushes a younger ready REG.
    do_reset();
    idle(); set_iss(2'd1, 0, 32'h100, 0, 0, 0); cycle();
    idle(); set_iss(2'd0, 5'd7, 32'h104, 0, 1, 32'h5); cycle();
    idle(); set_alu(4'd0, 0, 1, 32'h200); cycle();
    idle(); cycle();
    chk("mp_commit_br", 32'(commit_br), 1);
    chk("mp_rollback", 32'(rollback), 1);
    chk("mp_rollback_pc", rollback_pc, 32'h200);
    chk("mp_commit", 32'(commit), 0);
    idle(); set_iss(2'd0, 5'd8, 0, 0, 1, 0); cycle();
    chk("mp_pulse_end", 32'(rollback), 0);
    chk("mp_issue_dropped", 32'(issue_rob_pos), 0);
    for (int i = 0; i < 2; i++) begin
      idle(); cycle();
      chk("mp_no_younger_commit", 32'(commit), 0);
    end

    // Correct prediction, then taken-predicted branch that falls through.
    do_reset();
    idle(); set_iss(2'd1, 0, 32'h80, 1, 0, 0); cycle();
    idle(); set_iss(2'd1, 0, 32'h40, 1, 0, 0); cycle();
    idle(); set_alu(4'd0, 0, 1, 32'h300); cycle();
    idle(); set_alu(4'd1, 0, 0, 32'h500); cycle();
    chk("ok_commit_br", 32'(commit_br), 1);
    chk("ok_br_pc", commit_br_pc, 32'h80);
    chk("ok_no_rollback", 32'(rollback), 0);
    idle(); cycle();
    chk("nt_rollback", 32'(rollback), 1);
    chk("nt_rollback_pc", rollback_pc, 32'h44);
    chk("nt_br_jump", 32'(commit_br_jump), 0);

    // Query bypass: ALU beats LSB for the same position.
    do_reset();
    for (int i = 0; i < 6; i++) begin idle(); set_iss(2'd0, 5'(i + 1), 0, 0, 0, 0); cycle(); end
    idle(); rs1_q_pos = 4'd5; rs2_q_pos = 4'd4;
    set_alu(4'd5, 32'hDEAD, 0, 0);
    lsb_result = 1; lsb_rob_pos = 4'd5; lsb_val = 32'hBEEF;
    #1 chk("q_bypass_ready", 32'(rs1_q_ready), 1);
    chk("q_bypass_val", rs1_q_val, 32'hDEAD);
    chk("q_not_ready", 32'(rs2_q_ready), 0);
    cycle();
    idle(); rs1_q_pos = 4'd5;
    #1 chk("q_stored_val", rs1_q_val, 32'hDEAD);
    cycle();

    // Stall with a ready head holds everything, then reset mid-stream.
    do_reset();
    idle(); set_iss(2'd0, 5'd9, 0, 0, 1, 32'h99); cycle();
    idle(); set_iss(2'd0, 5'd10, 0, 0, 1, 32'hAA); cycle();
    chk("stall_first_commit_rd", 32'(commit_rd), 9);
    for (int i = 0; i < 3; i++) begin
      idle(); rdy = 0; set_iss(2'd0, 5'd11, 0, 0, 1, 0); cycle();
      chk("stall_hold_commit", 32'(commit), 1);
      chk("stall_hold_rd", 32'(commit_rd), 9);
    end
    idle(); cycle();
    chk("stall_resume_rd", 32'(commit_rd), 10);
    idle(); set_iss(2'd0, 5'd12, 0, 0, 0, 0); cycle();
    idle(); set_iss(2'd1, 5'd0, 32'h8, 0, 0, 0); cycle();
    idle(); rst = 1; rdy = 0; cycle();
    chk("rst_commit", 32'(commit), 0);
    chk("rst_val", commit_val, 0);
    chk("rst_full", 32'(rob_full), 0);
    chk("rst_pos", 32'(issue_rob_pos), 0);

    // Random traffic against the model.
    idle();
    for (int c = 0; c < 3000; c++) begin
      idle();
      rdy = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 9) < 6)
        set_iss(2'($urandom_range(0, 3)), 5'($urandom), $urandom & 32'hFFFF_FFFC,
                1'($urandom), $urandom_range(0, 9) < 3, $urandom);
      if (q.size() > 0 && $urandom_range(0, 9) < 6) begin
        idx = $urandom_range(0, q.size() - 1);
        set_alu(4'(q[idx].pos), $urandom, q[idx].pred ^ ($urandom_range(0, 5) == 0), $urandom & 32'hFFFF_FFFC);
      end
      if ($urandom_range(0, 9) < 4) begin
        idx2 = (q.size() > 0 && $urandom_range(0, 3) != 0) ? q[$urandom_range(0, q.size() - 1)].pos
                                                          : $urandom_range(0, 15);
        if (!(alu_result && alu_rob_pos == 4'(idx2))) begin
          lsb_result = 1; lsb_rob_pos = 4'(idx2); lsb_val = $urandom;
        end
      end
      rs1_q_pos = 4'($urandom); rs2_q_pos = 4'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
